onehot_stat_unit: RTL and testbench
===================================

Name: onehot_stat_unit

Overview:
- Parametrised decode/classify/count unit.
- Each cycle with iEN high, it decodes an SEL_W-bit index to a one-hot word of 2**SEL_W bits and registers it.
- The registered word is arithmetic-shifted right and compared against a threshold.
- Separate counters tally valid samples whose one-hot LSB is 0 (even class) or 1 (odd class).
- Sits in the test-group datapath as the generalised classifier/statistics stage.

Parameters:
- SEL_W, 3, index width; one-hot word width DW = 2**SEL_W (min 2, max 5).
- SHIFT, 2, arithmetic right-shift amount applied to the registered word (0..DW-1).
- THRESH, 3, unsigned compare threshold, DW bits wide.
- CNT_W, 4, width of each class counter.

Ports:
- iCLK  in  1  clock, rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iEN  in  1  sample qualifier; iDEC is captured only when iEN=1.
- iCLR  in  1  synchronous clear of both counters and the overflow flags.
- iDEC  in  SEL_W  index to decode.
- oVLD  out  1  registered word holds a valid sample.
- oWORD  out  DW  registered one-hot word.
- oGREAT  out  1  shifted word > THRESH (unsigned), gated by oVLD.
- oCNTP  out  CNT_W  even-class count.
- oCNTN  out  CNT_W  odd-class count.
- oOVFP, oOVFN  out  1 each  sticky wrap flags; present only with the optional feature.

Behaviour:
- Reset (iRST=1, async): oWORD=0, oVLD=0, oGREAT=0, oCNTP=0, oCNTN=0, oOVFP=0, oOVFN=0. Reset mid-operation discards the in-flight sample; no partial counts.
- Decode: combinational, sDEC = 1 << iDEC. Every index value is legal.
- Stage 1, edge k:
  - If iEN=1: oWORD <= sDEC, oVLD <= 1.
  - Else: oWORD holds, oVLD <= 0.
- Shift/compare: combinational from oWORD.
  - sSHIFT = oWORD >>> SHIFT, sign = oWORD[DW-1].
  - oGREAT = oVLD & (sSHIFT > THRESH), unsigned DW-bit compare.
  - Latency iDEC to oGREAT: 1 cycle.
- Counters update at edge k+1, only when oVLD=1:
  - oWORD[0]=0 increments oCNTP.
  - oWORD[0]=1 increments oCNTN.
  - Exactly one counter moves per valid sample.
  - Latency iDEC to count: 2 cycles.
- Wrap: counters are modulo 2**CNT_W (all-ones to 0).
- iCLR=1: both counters go to 0 on the next edge. Clear wins over a simultaneous increment. The stage-1 register is unaffected.
- Back-to-back iEN=1 samples are accepted every cycle with no bubbles.

Optional Feature:
- Macro: ONEHOT_STAT_OVF_EN.
- Defined:
  - Ports oOVFP and oOVFN exist.
  - Each flag sets on the edge its counter wraps from all-ones to 0 by increment.
  - Each flag stays set until iCLR or iRST.
  - If iCLR and a wrapping increment coincide, the flag ends at 0.
- Undefined: the flag ports and flag logic are absent. Counter behaviour is identical.

Decomposition:
- Package onehot_stat_pkg:
  - localparam defaults for SEL_W, SHIFT, THRESH, CNT_W.
  - function onehot_dec(sel) returning the DW-bit word.
  - function asr(word, n).
- Sub-module class_counter:
  - CNT_W-bit counter with inc, clr, iRST.
  - Optional sticky wrap flag under the same macro.
  - Instantiated twice (even and odd class).

Test Plan:
- iRST pulse mid-stream, with iEN=1 and iDEC=7 held → during reset all outputs = 0. On the first edge after release, oWORD=0x80 and oVLD=1.
- iEN=1, iDEC sequence 0,3,4,7 on consecutive edges:
  - oWORD = 0x01, 0x08, 0x10, 0x80.
  - oGREAT = 0, 0, 1, 1, since sSHIFT = 0x00, 0x02, 0x04, 0xE0.
  - Two cycles after the last sample: oCNTP=3, oCNTN=1.
- iEN=0 for 5 cycles after one sample of iDEC=2 → oVLD=0, oGREAT=0, oCNTP advances by exactly 1, oCNTN unchanged.
- 16 consecutive samples of iDEC=1 with CNT_W=4 → oCNTP wraps 15→0. With ONEHOT_STAT_OVF_EN, oOVFP=1 from the wrap edge onward; oOVFN=0.
- iCLR=1 coinciding with a valid odd sample (iDEC=0), oCNTN=5 → next edge oCNTN=0 and oOVFN=0.
- Parameter sweep SEL_W=4, SHIFT=3, THRESH=0x0100, iDEC=15 → oWORD=0x8000, sSHIFT=0xF000, oGREAT=1.

Source files
------------

// File: rtl/onehot_stat_pkg.sv
// onehot_stat_pkg: shared defaults and helpers for onehot_stat_unit.
// Provides the one-hot decoder and a width-aware arithmetic right shift.
package onehot_stat_pkg;

  localparam int SEL_W_DEF  = 3;
  localparam int SHIFT_DEF  = 2;
  localparam int THRESH_DEF = 3;
  localparam int CNT_W_DEF  = 4;

  localparam int SEL_MAX = 5;
  localparam int DW_MAX  = 32;

  function automatic logic [DW_MAX-1:0] onehot_dec(
    input logic [SEL_MAX-1:0] sel
  );
    return DW_MAX'(1) << sel;
  endfunction

  // The sign bit is bit dw-1 of the narrow word, so the word is first
  // moved to the top of the wide container, sign-extended back down,
  // then shifted by n.
  function automatic logic [DW_MAX-1:0] asr(
    input logic [DW_MAX-1:0] word,
    input int                n,
    input int                dw
  );
    logic signed [DW_MAX-1:0] t;
    t = $signed(word << (DW_MAX - dw));
    t = t >>> (DW_MAX - dw);
    return t >>> n;
  endfunction

endpackage

// File: rtl/class_counter.sv
// class_counter: CNT_W-bit wrapping counter with sync clear.
// Ports: iCLK, iRST (async high), iINC, iCLR, oCNT; oOVF with ONEHOT_STAT_OVF_EN.
module class_counter
  import onehot_stat_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iINC,
  input  logic             iCLR,
  output logic [CNT_W-1:0] oCNT
`ifdef ONEHOT_STAT_OVF_EN
  ,
  output logic             oOVF
`endif
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_cnt <= '0;
    end else if (iCLR) begin
      r_cnt <= '0;
    end else if (iINC) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign oCNT = r_cnt;

`ifdef ONEHOT_STAT_OVF_EN
  logic r_ovf;
  logic w_wrap;

  assign w_wrap = iINC & (&r_cnt);

  // Clear has priority, so a wrap on the clearing edge leaves 0.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_ovf <= 1'b0;
    end else if (iCLR) begin
      r_ovf <= 1'b0;
    end else if (w_wrap) begin
      r_ovf <= 1'b1;
    end
  end

  assign oOVF = r_ovf;
`endif

endmodule

// File: rtl/onehot_stat_unit.sv
// onehot_stat_unit: decode index to one-hot, register, shift/compare, count.
// Ports: iCLK, iRST, iEN, iCLR, iDEC -> oVLD, oWORD, oGREAT, oCNTP, oCNTN;
// oOVFP/oOVFN only when ONEHOT_STAT_OVF_EN is defined.
module onehot_stat_unit
  import onehot_stat_pkg::*;
#(
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int THRESH = THRESH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iEN,
  input  logic                  iCLR,
  input  logic [SEL_W-1:0]      iDEC,
  output logic                  oVLD,
  output logic [(1<<SEL_W)-1:0] oWORD,
  output logic                  oGREAT,
  output logic [CNT_W-1:0]      oCNTP,
  output logic [CNT_W-1:0]      oCNTN
`ifdef ONEHOT_STAT_OVF_EN
  ,
  output logic                  oOVFP,
  output logic                  oOVFN
`endif
);

  localparam int DW = 1 << SEL_W;
  localparam logic [DW-1:0] TH = DW'(THRESH);

  logic [SEL_MAX-1:0] w_sel;
  logic [DW-1:0]      w_dec;
  logic [DW-1:0]      w_shift;
  logic               w_inc_p;
  logic               w_inc_n;
  logic [DW-1:0]      r_word;
  logic               r_vld;

  assign w_sel = SEL_MAX'(iDEC);
  assign w_dec = DW'(onehot_dec(w_sel));

  // The word holds when idle; only the valid bit drops.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_word <= '0;
      r_vld  <= 1'b0;
    end else if (iEN) begin
      r_word <= w_dec;
      r_vld  <= 1'b1;
    end else begin
      r_vld  <= 1'b0;
    end
  end

  assign w_shift = DW'(asr(DW_MAX'(r_word), SHIFT, DW));

  assign oVLD   = r_vld;
  assign oWORD  = r_word;
  assign oGREAT = r_vld & (w_shift > TH);

  assign w_inc_p = r_vld & ~r_word[0];
  assign w_inc_n = r_vld &  r_word[0];

  class_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_p (
    .iCLK (iCLK),
    .iRST (iRST),
    .iINC (w_inc_p),
    .iCLR (iCLR),
    .oCNT (oCNTP)
`ifdef ONEHOT_STAT_OVF_EN
    ,
    .oOVF (oOVFP)
`endif
  );

  class_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_n (
    .iCLK (iCLK),
    .iRST (iRST),
    .iINC (w_inc_n),
    .iCLR (iCLR),
    .oCNT (oCNTN)
`ifdef ONEHOT_STAT_OVF_EN
    ,
    .oOVF (oOVFN)
`endif
  );

endmodule

// File: tb/tb_onehot_stat_unit.sv
// tb_onehot_stat_unit: self-checking bench for onehot_stat_unit.
// Default instance plus a wide (SEL_W=4) instance for the parameter sweep.
module tb_onehot_stat_unit;

  localparam int SEL_W  = 3;
  localparam int DW     = 8;
  localparam int SHIFT  = 2;
  localparam int THRESH = 3;
  localparam int CNT_W  = 4;
  localparam int CMOD   = 16;

  logic       iCLK;
  logic       iRST;
  logic       iEN;
  logic       iCLR;
  logic [2:0] iDEC;
  logic       oVLD;
  logic [7:0] oWORD;
  logic       oGREAT;
  logic [3:0] oCNTP;
  logic [3:0] oCNTN;
`ifdef ONEHOT_STAT_OVF_EN
  logic       oOVFP;
  logic       oOVFN;
  logic       w_ovfp;
  logic       w_ovfn;
`endif

  logic        w_en;
  logic        w_clr;
  logic [3:0]  w_dec;
  logic        w_vld;
  logic [15:0] w_word;
  logic        w_great;
  logic [3:0]  w_cntp;
  logic [3:0]  w_cntn;

  int total = 0;
  int bad   = 0;

  bit     m_vld;
  longint m_word;
  int     m_cp;
  int     m_cn;
  bit     m_op;
  bit     m_on;

  onehot_stat_unit #(
    .SEL_W  (SEL_W),
    .SHIFT  (SHIFT),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iEN    (iEN),
    .iCLR   (iCLR),
    .iDEC   (iDEC),
    .oVLD   (oVLD),
    .oWORD  (oWORD),
    .oGREAT (oGREAT),
    .oCNTP  (oCNTP),
    .oCNTN  (oCNTN)
`ifdef ONEHOT_STAT_OVF_EN
    ,
    .oOVFP  (oOVFP),
    .oOVFN  (oOVFN)
`endif
  );

  onehot_stat_unit #(
    .SEL_W  (4),
    .SHIFT  (3),
    .THRESH (32'h0100),
    .CNT_W  (4)
  ) dut_w (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iEN    (w_en),
    .iCLR   (w_clr),
    .iDEC   (w_dec),
    .oVLD   (w_vld),
    .oWORD  (w_word),
    .oGREAT (w_great),
    .oCNTP  (w_cntp),
    .oCNTN  (w_cntn)
`ifdef ONEHOT_STAT_OVF_EN
    ,
    .oOVFP  (w_ovfp),
    .oOVFN  (w_ovfn)
`endif
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  // Arithmetic shift computed as signed division of the word's value.
  function automatic longint ref_shift(
    input longint word, input int dw, input int sh
  );
    longint one;
    longint v;
    one = 1;
    v = word;
    if (word >= (one << (dw - 1))) v = word - (one << dw);
    v = v / (one << sh);
    if (v < 0) v = v + (one << dw);
    return v;
  endfunction

  task automatic model_reset();
    m_vld  = 0;
    m_word = 0;
    m_cp   = 0;
    m_cn   = 0;
    m_op   = 0;
    m_on   = 0;
  endtask

  task automatic model_edge(input bit en, input int dec, input bit clr);
    if (clr) begin
      m_cp = 0;
      m_cn = 0;
      m_op = 0;
      m_on = 0;
    end else if (m_vld) begin
      if (m_word % 2 == 1) begin
        if (m_cn == CMOD - 1) m_on = 1;
        m_cn = (m_cn + 1) % CMOD;
      end else begin
        if (m_cp == CMOD - 1) m_op = 1;
        m_cp = (m_cp + 1) % CMOD;
      end
    end
    if (en) begin
      m_vld  = 1;
      m_word = longint'(1) << dec;
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic step(input bit en, input int dec, input bit clr);
    iEN  = en;
    iDEC = 3'(dec);
    iCLR = clr;
    @(posedge iCLK);
    model_edge(en, dec, clr);
    @(negedge iCLK);
  endtask

  task automatic test_reset();
    repeat (4) step(1, $urandom_range(0, 7), 0);
    iEN  = 1;
    iDEC = 3'd7;
    iCLR = 0;
    iRST = 1;
    #1;
    total++;
    if ({oVLD, oWORD, oGREAT, oCNTP, oCNTN} !== 18'd0) begin
      bad++;
      $display("FAIL rst_async got=%h exp=0",
        {oVLD, oWORD, oGREAT, oCNTP, oCNTN});
    end
`ifdef ONEHOT_STAT_OVF_EN
    total++;
    if ({oOVFP, oOVFN} !== 2'b00) begin
      bad++;
      $display("FAIL rst_ovf got=%b exp=00", {oOVFP, oOVFN});
    end
`endif
    @(posedge iCLK);
    @(negedge iCLK);
    total++;
    if ({oVLD, oWORD, oCNTP, oCNTN} !== 17'd0) begin
      bad++;
      $display("FAIL rst_held got=%h exp=0",
        {oVLD, oWORD, oCNTP, oCNTN});
    end
    iRST = 0;
    model_reset();
    @(posedge iCLK);
    model_edge(1, 7, 0);
    @(negedge iCLK);
    total++;
    if (oWORD !== 8'h80 || oVLD !== 1'b1) begin
      bad++;
      $display("FAIL rst_release word=%h vld=%b exp=80/1",
        oWORD, oVLD);
    end
  endtask

  task automatic test_sequence();
    int     decs [4]  = '{0, 3, 4, 7};
    longint words [4] = '{8'h01, 8'h08, 8'h10, 8'h80};
    bit     grts [4]  = '{0, 0, 1, 1};
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, decs[i], 0);
      total++;
      if (longint'(oWORD) !== words[i] || oGREAT !== grts[i]) begin
        bad++;
        $display("FAIL seq_%0d word=%h great=%b exp=%h/%b",
          i, oWORD, oGREAT, words[i], grts[i]);
      end
    end
    step(0, 0, 0);
    step(0, 0, 0);
    total++;
    if (oCNTP !== 4'd3 || oCNTN !== 4'd1) begin
      bad++;
      $display("FAIL seq_cnt p=%0d n=%0d exp=3/1", oCNTP, oCNTN);
    end
  endtask

  task automatic test_idle();
    step(0, 0, 1);
    step(1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      total++;
      if (oVLD !== 1'b0 || oGREAT !== 1'b0 || oWORD !== 8'h04) begin
        bad++;
        $display("FAIL idle_%0d vld=%b great=%b word=%h exp=0/0/04",
          i, oVLD, oGREAT, oWORD);
      end
    end
    total++;
    if (oCNTP !== 4'd1 || oCNTN !== 4'd0) begin
      bad++;
      $display("FAIL idle_cnt p=%0d n=%0d exp=1/0", oCNTP, oCNTN);
    end
  endtask

  task automatic test_wrap();
    step(0, 0, 1);
    repeat (16) step(1, 1, 0);
    total++;
    if (oCNTP !== 4'd15) begin
      bad++;
      $display("FAIL wrap_pre got=%0d exp=15", oCNTP);
    end
`ifdef ONEHOT_STAT_OVF_EN
    total++;
    if (oOVFP !== 1'b0) begin
      bad++;
      $display("FAIL wrap_pre_ovf got=%b exp=0", oOVFP);
    end
`endif
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      total++;
      if (oCNTP !== 4'd0 || oCNTN !== 4'd0) begin
        bad++;
        $display("FAIL wrap_%0d p=%0d n=%0d exp=0/0",
          i, oCNTP, oCNTN);
      end
`ifdef ONEHOT_STAT_OVF_EN
      total++;
      if (oOVFP !== 1'b1 || oOVFN !== 1'b0) begin
        bad++;
        $display("FAIL wrap_ovf_%0d got=%b%b exp=10",
          i, oOVFP, oOVFN);
      end
`endif
    end
  endtask

  task automatic test_clr_collision();
    int ns [2] = '{5, 15};
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1);
      repeat (ns[k]) step(1, 0, 0);
      step(0, 0, 0);
      total++;
      if (int'(oCNTN) !== ns[k]) begin
        bad++;
        $display("FAIL clr_pre_%0d got=%0d exp=%0d", k, oCNTN, ns[k]);
      end
      step(1, 0, 0);
      step(0, 0, 1);
      total++;
      if (oCNTN !== 4'd0) begin
        bad++;
        $display("FAIL clr_cnt_%0d got=%0d exp=0", k, oCNTN);
      end
`ifdef ONEHOT_STAT_OVF_EN
      total++;
      if (oOVFN !== 1'b0) begin
        bad++;
        $display("FAIL clr_ovf_%0d got=%b exp=0", k, oOVFN);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      int d;
      d = $urandom_range(0, 7);
      step(1, d, 0);
      total++;
      if (longint'(oWORD) !== (longint'(1) << d) || oVLD !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d word=%h vld=%b dec=%0d",
          i, oWORD, oVLD, d);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit en;
      bit clr;
      bit eg;
      int d;
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      d   = $urandom_range(0, 7);
      step(en, d, clr);
      eg = m_vld && (ref_shift(m_word, DW, SHIFT) > THRESH);
      total++;
      if (longint'(oWORD) !== m_word || oVLD !== m_vld ||
          oGREAT !== eg) begin
        bad++;
        $display("FAIL rnd_stage c=%0d got=%h/%b/%b exp=%h/%b/%b",
          i, oWORD, oVLD, oGREAT, m_word, m_vld, eg);
      end
      total++;
      if (int'(oCNTP) !== m_cp || int'(oCNTN) !== m_cn) begin
        bad++;
        $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d",
          i, oCNTP, oCNTN, m_cp, m_cn);
      end
`ifdef ONEHOT_STAT_OVF_EN
      total++;
      if (oOVFP !== m_op || oOVFN !== m_on) begin
        bad++;
        $display("FAIL rnd_ovf c=%0d got=%b%b exp=%b%b",
          i, oOVFP, oOVFN, m_op, m_on);
      end
`endif
    end
  endtask

  task automatic test_sweep();
    int          decs [3] = '{15, 11, 12};
    logic [15:0] wds [3]  = '{16'h8000, 16'h0800, 16'h1000};
    bit          grts [3] = '{1, 0, 1};
    w_clr = 1;
    step(0, 0, 0);
    w_clr = 0;
    for (int i = 0; i < 3; i++) begin
      w_en  = 1;
      w_dec = 4'(decs[i]);
      step(0, 0, 0);
      total++;
      if (w_word !== wds[i] || w_great !== grts[i] ||
          w_vld !== 1'b1) begin
        bad++;
        $display("FAIL sweep_%0d word=%h great=%b vld=%b exp=%h/%b/1",
          i, w_word, w_great, w_vld, wds[i], grts[i]);
      end
    end
    w_en = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    total++;
    if (w_cntp !== 4'd3 || w_cntn !== 4'd0 || w_great !== 1'b0) begin
      bad++;
      $display("FAIL sweep_cnt p=%0d n=%0d great=%b exp=3/0/0",
        w_cntp, w_cntn, w_great);
    end
`ifdef ONEHOT_STAT_OVF_EN
    total++;
    if ({w_ovfp, w_ovfn} !== 2'b00) begin
      bad++;
      $display("FAIL sweep_ovf got=%b%b exp=00", w_ovfp, w_ovfn);
    end
`endif
  endtask

  initial begin
    iRST  = 1;
    iEN   = 0;
    iCLR  = 0;
    iDEC  = '0;
    w_en  = 0;
    w_clr = 0;
    w_dec = '0;
    model_reset();
    repeat (2) @(negedge iCLK);
    iRST = 0;
    test_reset();
    test_sequence();
    test_idle();
    test_wrap();
    test_clr_collision();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
